// File: rtl/network_host.sv
// Host-side sequencer for the bitstream network controller: latches one input
// vector per request, pulses start, waits for finish (with watchdog), returns outputs.
module network_host #(
   parameter int INPUT_SIZE  = 2,
   parameter int OUTPUT_SIZE = 1,
   parameter int TIMEOUT     = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic signed [31:0] req_data     [0:INPUT_SIZE-1],
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic signed [31:0] resp_data    [0:OUTPUT_SIZE-1],
   output logic               resp_timeout,
   output logic               busy,
   output logic [1:0]         ctrl_state,
   output logic [7:0]         control_out,
   input  logic [7:0]         control_in,
   output logic signed [31:0] net_data_in  [0:INPUT_SIZE-1],
   input  logic signed [31:0] net_data_out [0:OUTPUT_SIZE-1]
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [CW-1:0]      cnt_d;
   logic               start_q;
   logic               busy_q;
   logic               resp_valid_q;
   logic               resp_timeout_q;
   logic [1:0]         ctrl_state_q;
   logic signed [31:0] resp_data_q   [0:OUTPUT_SIZE-1];
   logic signed [31:0] net_data_in_q [0:INPUT_SIZE-1];
   logic               ctrl_unused_s;

   // Status bits 5:1 carry nothing this host consumes.
   assign ctrl_unused_s = ^control_in[5:1];

   // Saturating watchdog increment.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         start_q        <= 1'b0;
         busy_q         <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
         ctrl_state_q   <= 2'b00;
         for (int i = 0; i < OUTPUT_SIZE; i++) begin
            resp_data_q[i] <= 32'sd0;
         end
         for (int i = 0; i < INPUT_SIZE; i++) begin
            net_data_in_q[i] <= 32'sd0;
         end
      end else begin
         ctrl_state_q <= control_in[7:6];
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  net_data_in_q <= req_data;
                  start_q       <= 1'b1;
                  busy_q        <= 1'b1;
                  state_q       <= S_START;
               end
            end
            S_START: begin
               start_q <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_d;
               // Finish has priority over a coincident watchdog expiry.
               if (control_in[0]) begin
                  resp_data_q    <= net_data_out;
                  resp_timeout_q <= 1'b0;
                  resp_valid_q   <= 1'b1;
                  state_q        <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  for (int i = 0; i < OUTPUT_SIZE; i++) begin
                     resp_data_q[i] <= 32'sd0;
                  end
                  resp_timeout_q <= 1'b1;
                  resp_valid_q   <= 1'b1;
                  state_q        <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               start_q      <= 1'b0;
               busy_q       <= 1'b0;
               resp_valid_q <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = (state_q == S_IDLE);
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_timeout = resp_timeout_q;
   assign busy         = busy_q;
   assign ctrl_state   = ctrl_state_q;
   assign control_out  = {7'b000_0000, start_q};
   assign net_data_in  = net_data_in_q;

endmodule

// File: tb/tb_network_host.sv
// Directed scoreboard bench for network_host: instance a uses the default watchdog,
// instance b uses TIMEOUT=16 for the watchdog and finish/timeout race cases.
module tb_network_host;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic               a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_timeout, a_busy;
   logic signed [31:0] a_req_data [0:1];
   logic signed [31:0] a_resp_data [0:0];
   logic signed [31:0] a_net_data_in [0:1];
   logic signed [31:0] a_net_data_out [0:0];
   logic [1:0]         a_ctrl_state;
   logic [7:0]         a_control_out, a_control_in;

   logic               b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_timeout, b_busy;
   logic signed [31:0] b_req_data [0:1];
   logic signed [31:0] b_resp_data [0:0];
   logic signed [31:0] b_net_data_in [0:1];
   logic signed [31:0] b_net_data_out [0:0];
   logic [1:0]         b_ctrl_state;
   logic [7:0]         b_control_out, b_control_in;

   network_host #(.INPUT_SIZE(2), .OUTPUT_SIZE(1), .TIMEOUT(1024)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_data(a_req_data),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
      .resp_timeout(a_resp_timeout), .busy(a_busy), .ctrl_state(a_ctrl_state),
      .control_out(a_control_out), .control_in(a_control_in),
      .net_data_in(a_net_data_in), .net_data_out(a_net_data_out)
   );

   network_host #(.INPUT_SIZE(2), .OUTPUT_SIZE(1), .TIMEOUT(16)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
      .resp_timeout(b_resp_timeout), .busy(b_busy), .ctrl_state(b_ctrl_state),
      .control_out(b_control_out), .control_in(b_control_in),
      .net_data_in(b_net_data_in), .net_data_out(b_net_data_out)
   );

   typedef struct {
      int   data;
      logic to;
   } exp_t;

   exp_t sbq [$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc;
   int   pulses;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sb_compare(input string tag, input logic signed [31:0] d, input logic to);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=response expected=empty_scoreboard", tag);
      end else begin
         e = sbq.pop_front();
         check({tag, "_data"}, d, e.data);
         check({tag, "_timeout"}, {31'd0, to}, {31'd0, e.to});
      end
   endtask

   // Issue one request on instance a; the controller model raises finish in cycle fin_at after START.
   task automatic run_a(input int d0, input int d1, input int fin_at, input int fval,
                        output int n, output int p);
      a_req_data[0] = d0;
      a_req_data[1] = d1;
      a_req_valid   = 1'b1;
      check("a_req_ready_idle", {31'd0, a_req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      check("a_start_ctrl", {24'd0, a_control_out}, 32'h01);
      check("a_start_busy", {31'd0, a_busy}, 32'd1);
      check("a_start_req_ready", {31'd0, a_req_ready}, 32'd0);
      check("a_net_data_in0", a_net_data_in[0], d0);
      check("a_net_data_in1", a_net_data_in[1], d1);
      n = 0;
      p = a_control_out[0] ? 1 : 0;
      while (a_resp_valid !== 1'b1 && n < 2000) begin
         if (n == fin_at) begin
            a_control_in      = 8'h01;
            a_net_data_out[0] = fval;
         end else begin
            a_control_in = 8'h00;
         end
         @(negedge clk);
         n++;
         if (a_control_out[0] === 1'b1) p++;
         if (n == 2) check("a_wait_ctrl", {24'd0, a_control_out}, 32'h00);
      end
      a_control_in = 8'h00;
      check("a_resp_valid_up", {31'd0, a_resp_valid}, 32'd1);
   endtask

   // Same sequence on instance b; fin_at < 0 means finish never comes.
   task automatic run_b(input int d0, input int d1, input int fin_at, input int fval,
                        output int n);
      b_req_data[0] = d0;
      b_req_data[1] = d1;
      b_req_valid   = 1'b1;
      check("b_req_ready_idle", {31'd0, b_req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      b_req_valid = 1'b0;
      check("b_start_ctrl", {24'd0, b_control_out}, 32'h01);
      n = 0;
      while (b_resp_valid !== 1'b1 && n < 200) begin
         if (n == fin_at) begin
            b_control_in      = 8'h01;
            b_net_data_out[0] = fval;
         end else begin
            b_control_in = 8'h00;
         end
         @(negedge clk);
         n++;
      end
      b_control_in = 8'h00;
      check("b_resp_valid_up", {31'd0, b_resp_valid}, 32'd1);
   endtask

   task automatic b_handshake();
      b_resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_resp_ready = 1'b0;
      check("b_hs_req_ready", {31'd0, b_req_ready}, 32'd1);
      check("b_hs_resp_valid", {31'd0, b_resp_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      a_req_valid = 1'b0; a_resp_ready = 1'b0; a_control_in = 8'h00;
      a_req_data[0] = 32'sd0; a_req_data[1] = 32'sd0; a_net_data_out[0] = 32'sd0;
      b_req_valid = 1'b0; b_resp_ready = 1'b0; b_control_in = 8'h00;
      b_req_data[0] = 32'sd0; b_req_data[1] = 32'sd0; b_net_data_out[0] = 32'sd0;
      @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
      check("rst_resp_timeout", {31'd0, a_resp_timeout}, 32'd0);
      check("rst_busy", {31'd0, a_busy}, 32'd0);
      check("rst_control_out", {24'd0, a_control_out}, 32'h00);
      check("rst_ctrl_state", {30'd0, a_ctrl_state}, 32'd0);
      check("rst_resp_data", a_resp_data[0], 32'd0);
      check("rst_net_data_in", a_net_data_in[0], 32'd0);
      rst = 1'b0;

      // Stale finish while idle, status tracking with one cycle of delay.
      a_control_in = 8'hC1;
      @(posedge clk);
      @(negedge clk);
      check("stale_ctrl_state_3", {30'd0, a_ctrl_state}, 32'd3);
      a_control_in = 8'h81;
      check("stale_ctrl_state_hold", {30'd0, a_ctrl_state}, 32'd3);
      @(posedge clk);
      @(negedge clk);
      check("stale_ctrl_state_2", {30'd0, a_ctrl_state}, 32'd2);
      a_control_in = 8'h00;
      @(posedge clk);
      @(negedge clk);
      check("stale_no_resp", {31'd0, a_resp_valid}, 32'd0);
      check("stale_not_busy", {31'd0, a_busy}, 32'd0);
      check("stale_ctrl_state_0", {30'd0, a_ctrl_state}, 32'd0);

      // Nominal run: finish 257 cycles after START.
      sbq.push_back('{data: 42, to: 1'b0});
      run_a(100, 200, 257, 42, cyc, pulses);
      check("nom_latency", cyc, 32'd258);
      check("nom_start_pulses", pulses, 32'd1);
      a_net_data_out[0] = 32'sd77;
      sb_compare("nom", a_resp_data[0], a_resp_timeout);

      // Back-pressure with changing controller data and a rejected request.
      for (int i = 0; i < 10; i++) begin
         check("bp_data", a_resp_data[0], 32'd42);
         check("bp_valid", {31'd0, a_resp_valid}, 32'd1);
         a_req_valid = (i == 4);
         if (i == 4) begin
            a_req_data[0] = 32'sd1;
            a_req_data[1] = 32'sd2;
            check("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
         end
         @(posedge clk);
         @(negedge clk);
         a_net_data_out[0] = 32'sd78 + i;
      end
      a_req_valid = 1'b0;
      check("bp_ndi0_kept", a_net_data_in[0], 32'd100);
      check("bp_ndi1_kept", a_net_data_in[1], 32'd200);
      a_resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_resp_ready = 1'b0;
      check("bp_idle_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("bp_idle_resp_valid", {31'd0, a_resp_valid}, 32'd0);
      check("bp_idle_busy", {31'd0, a_busy}, 32'd0);

      // Watchdog: finish never comes.
      b_net_data_out[0] = 32'sd55;
      sbq.push_back('{data: 0, to: 1'b1});
      run_b(3, 4, -1, 0, cyc);
      check("wd_latency", cyc, 32'd17);
      sb_compare("wd", b_resp_data[0], b_resp_timeout);
      b_handshake();

      // Finish on the 16th WAIT cycle beats the watchdog.
      sbq.push_back('{data: 7, to: 1'b0});
      run_b(5, 6, 16, 7, cyc);
      check("race_latency", cyc, 32'd17);
      sb_compare("race", b_resp_data[0], b_resp_timeout);
      b_handshake();

      // Reset in WAIT cycle 50 aborts without a response.
      a_req_data[0] = 32'sd8;
      a_req_data[1] = 32'sd9;
      a_req_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      repeat (50) @(negedge clk);
      check("mid_busy_before", {31'd0, a_busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("mid_rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
      check("mid_rst_control_out", {24'd0, a_control_out}, 32'h00);
      check("mid_rst_resp_data", a_resp_data[0], 32'd0);
      check("mid_rst_net_data_in", a_net_data_in[0], 32'd0);
      check("mid_rst_timeout", {31'd0, a_resp_timeout}, 32'd0);
      a_control_in = 8'h01;
      @(posedge clk);
      @(negedge clk);
      a_control_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         check("mid_late_finish_ignored", {31'd0, a_resp_valid}, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end

      // Normal run afterwards with resp_ready already high: one-cycle response.
      a_resp_ready = 1'b1;
      sbq.push_back('{data: 123, to: 1'b0});
      run_a(11, 22, 5, 123, cyc, pulses);
      check("post_latency", cyc, 32'd6);
      check("post_start_pulses", pulses, 32'd1);
      sb_compare("post", a_resp_data[0], a_resp_timeout);
      @(posedge clk);
      @(negedge clk);
      a_resp_ready = 1'b0;
      check("post_resp_one_cycle", {31'd0, a_resp_valid}, 32'd0);
      check("post_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("sb_drained", sbq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
